// File: rtl/ip_checksum_stream_if.sv
// Stream interface for ip_checksum_stream: input beat handshake plus the held
// result handshake. The packet source/sink uses master, the checksum block uses slave.
interface ip_checksum_stream_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int LANES = DATA_WIDTH / 16;

  logic                  mode;
  logic [DATA_WIDTH-1:0] s_data;
  logic [LANES-1:0]      s_lane_en;
  logic                  s_last;
  logic                  s_valid;
  logic                  s_ready;
  logic [15:0]           m_checksum;
  logic                  m_ok;
  logic                  m_err;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output mode, s_data, s_lane_en, s_last, s_valid, m_ready,
    input  s_ready, m_checksum, m_ok, m_err, m_valid
  );

  modport slave (
    input  mode, s_data, s_lane_en, s_last, s_valid, m_ready,
    output s_ready, m_checksum, m_ok, m_err, m_valid
  );
endinterface

// File: rtl/ip_checksum_stream.sv
// Streaming ones-complement checksum over 16-bit words: accumulate beats, fold
// the end-around carries twice, then hold one result per packet until accepted.
//
// state | meaning
// ACCUM | accepting beats, summing enabled lanes
// FOLD1 | first end-around carry fold
// FOLD2 | second fold, result registered
// DONE  | result held until m_ready
module ip_checksum_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  ip_checksum_stream_if.slave bus
);
  localparam int LANES = DATA_WIDTH / 16;
  localparam int ACC_W = 16 + $clog2(LANES * MAX_BEATS) + 1;
  localparam int CNT_W = $clog2(MAX_BEATS + 2);

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] FOLD1 = 2'd1;
  localparam logic [1:0] FOLD2 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] lane_sum;
  logic [ACC_W-1:0] fold;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             mode_q;
  logic [15:0]      checksum_q;
  logic             ok_q;
  logic             err_q;
  logic             valid_q;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.s_lane_en[LANES-1-i])
        lane_sum = lane_sum + ACC_W'(bus.s_data[DATA_WIDTH-1-16*i -: 16]);
    end
  end

  // After two folds the sum always fits 16 bits for any legal packet length.
  assign fold = ACC_W'(acc[15:0]) + ACC_W'(acc[ACC_W-1:16]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      mode_q     <= 1'b0;
      checksum_q <= 16'h0000;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.s_valid) begin
            acc <= acc + lane_sum;
            if (cnt == '0) mode_q <= bus.mode;
            if (cnt != CNT_W'(MAX_BEATS + 1)) cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(MAX_BEATS)) err <= 1'b1;
            if (bus.s_last) state <= FOLD1;
          end
        end
        FOLD1: begin
          acc   <= fold;
          state <= FOLD2;
        end
        FOLD2: begin
          acc        <= fold;
          checksum_q <= mode_q ? fold[15:0] : ~fold[15:0];
          ok_q       <= !err && (!mode_q || (fold[15:0] == 16'hFFFF));
          err_q      <= err;
          valid_q    <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (bus.m_ready) begin
            valid_q <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            state   <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.s_ready    = (state == ACCUM);
  assign bus.m_checksum = checksum_q;
  assign bus.m_ok       = ok_q;
  assign bus.m_err      = err_q;
  assign bus.m_valid    = valid_q;
endmodule

// File: tb/tb_ip_checksum_stream.sv
// Bench for ip_checksum_stream: four instances (16/32/64-bit, and a 4-beat limit),
// a word-sum reference model with an expected-result queue, and directed packets.
module tb_ip_checksum_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] d;
  logic [7:0]   len;
  logic         last, valid, mode, m_ready;
  int           sel;

  ip_checksum_stream_if #(.DATA_WIDTH(16)) i16  ();
  ip_checksum_stream_if #(.DATA_WIDTH(32)) i32  ();
  ip_checksum_stream_if #(.DATA_WIDTH(64)) i64  ();
  ip_checksum_stream_if #(.DATA_WIDTH(16)) i16s ();

  assign i16.mode = mode;   assign i16.s_data = d[15:0];  assign i16.s_lane_en = len[0:0];
  assign i16.s_last = last; assign i16.s_valid = valid && sel == 0; assign i16.m_ready = m_ready;
  assign i32.mode = mode;   assign i32.s_data = d[31:0];  assign i32.s_lane_en = len[1:0];
  assign i32.s_last = last; assign i32.s_valid = valid && sel == 1; assign i32.m_ready = m_ready;
  assign i64.mode = mode;   assign i64.s_data = d[63:0];  assign i64.s_lane_en = len[3:0];
  assign i64.s_last = last; assign i64.s_valid = valid && sel == 2; assign i64.m_ready = m_ready;
  assign i16s.mode = mode;  assign i16s.s_data = d[15:0]; assign i16s.s_lane_en = len[0:0];
  assign i16s.s_last = last; assign i16s.s_valid = valid && sel == 3; assign i16s.m_ready = m_ready;

  ip_checksum_stream #(.DATA_WIDTH(16), .MAX_BEATS(64)) u16  (.clk(clk), .rst_n(rst_n), .bus(i16));
  ip_checksum_stream #(.DATA_WIDTH(32), .MAX_BEATS(64)) u32  (.clk(clk), .rst_n(rst_n), .bus(i32));
  ip_checksum_stream #(.DATA_WIDTH(64), .MAX_BEATS(64)) u64  (.clk(clk), .rst_n(rst_n), .bus(i64));
  ip_checksum_stream #(.DATA_WIDTH(16), .MAX_BEATS(4))  u16s (.clk(clk), .rst_n(rst_n), .bus(i16s));

  logic        s_ready_m, s_valid_m, m_valid_m, m_ok_m, m_err_m;
  logic [15:0] cs_m;
  always_comb begin
    s_ready_m = i16.s_ready; s_valid_m = i16.s_valid; m_valid_m = i16.m_valid;
    m_ok_m = i16.m_ok; m_err_m = i16.m_err; cs_m = i16.m_checksum;
    case (sel)
      1: begin s_ready_m = i32.s_ready; s_valid_m = i32.s_valid; m_valid_m = i32.m_valid;
               m_ok_m = i32.m_ok; m_err_m = i32.m_err; cs_m = i32.m_checksum; end
      2: begin s_ready_m = i64.s_ready; s_valid_m = i64.s_valid; m_valid_m = i64.m_valid;
               m_ok_m = i64.m_ok; m_err_m = i64.m_err; cs_m = i64.m_checksum; end
      3: begin s_ready_m = i16s.s_ready; s_valid_m = i16s.s_valid; m_valid_m = i16s.m_valid;
               m_ok_m = i16s.m_ok; m_err_m = i16s.m_err; cs_m = i16s.m_checksum; end
      default: ;
    endcase
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: true integer word sum, folded until it fits 16 bits.
  typedef struct {logic [15:0] cs; logic ok; logic err;} res_t;
  res_t   expq[$];
  longint m_sum = 0;
  int     m_beats = 0;
  logic   m_mode = 1'b0;

  function automatic int lanes_of(input int s);
    return (s == 1) ? 2 : (s == 2) ? 4 : 1;
  endfunction

  function automatic int maxb_of(input int s);
    return (s == 3) ? 4 : 64;
  endfunction

  function automatic logic [15:0] fold16(input longint s);
    longint v = s;
    while (v > 65535) v = (v & 65535) + (v >> 16);
    return v[15:0];
  endfunction

  task automatic model_accept(input logic [127:0] dd, input logic [7:0] le, input logic ll);
    int L = lanes_of(sel);
    logic [15:0] f;
    res_t r;
    if (m_beats == 0) m_mode = mode;
    for (int i = 0; i < L; i++)
      if (le[L-1-i]) m_sum += 64'(dd[16*L-1-16*i -: 16]);
    m_beats++;
    if (ll) begin
      f     = fold16(m_sum);
      r.err = m_beats > maxb_of(sel);
      r.cs  = m_mode ? f : ~f;
      r.ok  = !r.err && (!m_mode || f == 16'hFFFF);
      expq.push_back(r);
      m_sum = 0;
      m_beats = 0;
    end
  endtask

  // Compare process: checks every cycle a result is presented.
  int          cyc = 0, cyc_l = 0, gap_run = 0, last_gap = 0, results = 0;
  logic        prev_mv = 1'b0;
  logic [15:0] last_cs;
  logic        last_ok, last_err;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mv = 1'b0;
      gap_run = 0;
    end else begin
      if (m_valid_m) begin
        chk("s_ready_low_while_result", {31'b0, s_ready_m}, 32'd0);
        if (expq.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          if (!expq[0].err) chk("m_checksum", {16'b0, cs_m}, {16'b0, expq[0].cs});
          chk("m_ok", {31'b0, m_ok_m}, {31'b0, expq[0].ok});
          chk("m_err", {31'b0, m_err_m}, {31'b0, expq[0].err});
          if (!prev_mv) chk("latency", cyc - cyc_l, 32'd3);
          if (m_ready) begin
            last_cs = cs_m; last_ok = m_ok_m; last_err = m_err_m;
            results++;
            void'(expq.pop_front());
          end
        end
      end
      if (s_valid_m && s_ready_m && last) cyc_l = cyc;
      if (!s_ready_m) gap_run++;
      else begin
        if (gap_run > 0) last_gap = gap_run;
        gap_run = 0;
      end
      prev_mv = m_valid_m;
    end
  end

  logic [127:0] pk_d[16];
  logic [7:0]   pk_le[16];

  task automatic clr_pk();
    for (int i = 0; i < 16; i++) begin pk_d[i] = '0; pk_le[i] = 8'hFF; end
  endtask

  task automatic beat(input logic [127:0] dd, input logic [7:0] le, input logic ll);
    int n = 0;
    d = dd; len = le; last = ll; valid = 1'b1;
    @(negedge clk);
    while (!s_ready_m && n < 50) begin n++; @(negedge clk); end
    if (!s_ready_m) chk("s_ready_timeout", 32'd0, 32'd1);
    else model_accept(dd, le, ll);
    @(posedge clk); #1;
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      beat(pk_d[i], pk_le[i], i == n - 1);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (expq.size() != 0 && n < 60) begin @(negedge clk); n++; end
    if (expq.size() != 0) begin
      chk("result_timeout", 32'(expq.size()), 32'd0);
      expq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_all();
    for (int k = 0; k < 4; k++) begin
      sel = k; #1;
      chk("rst_s_ready", {31'b0, s_ready_m}, 32'd1);
      chk("rst_m_valid", {31'b0, m_valid_m}, 32'd0);
      chk("rst_m_checksum", {16'b0, cs_m}, 32'd0);
      chk("rst_m_ok", {31'b0, m_ok_m}, 32'd0);
      chk("rst_m_err", {31'b0, m_err_m}, 32'd0);
    end
  endtask

  initial begin
    int n, rc0;
    d = '0; len = 8'hFF; last = 1'b0; valid = 1'b0; mode = 1'b0; m_ready = 1'b1; sel = 0;
    clr_pk();
    repeat (3) @(posedge clk); #1;
    chk_reset_all();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // generate, 32-bit
    sel = 1; mode = 1'b0;
    pk_d[0] = 128'h45000030; pk_d[1] = 128'h44224000; pk_d[2] = 128'h80060000;
    pk_d[3] = 128'h8C7C19AC; pk_d[4] = 128'hAE241E2B;
    send_pkt(5, 0); wait_done();
    chk("g32_cs", {16'b0, last_cs}, 32'h442E);
    chk("g32_ok", {31'b0, last_ok}, 32'd1);
    chk("g32_err", {31'b0, last_err}, 32'd0);

    // generate, 16-bit, then with the result held off
    sel = 0; clr_pk();
    pk_d[0] = 'h4500; pk_d[1] = 'h002E; pk_d[4] = 'h8000; pk_d[6] = 'h0101;
    pk_d[7] = 'h0B02; pk_d[8] = 'h0101; pk_d[9] = 'h0B01;
    send_pkt(10, 0); wait_done();
    chk("g16_cs", {16'b0, last_cs}, 32'h22CC);
    m_ready = 1'b0;
    send_pkt(10, 0);
    n = 0;
    while (!m_valid_m && n < 20) begin @(negedge clk); n++; end
    chk("hold_result_seen", {31'b0, m_valid_m}, 32'd1);
    repeat (5) @(negedge clk);
    chk("hold_still_valid", {31'b0, m_valid_m}, 32'd1);
    chk("hold_cs", {16'b0, cs_m}, 32'h22CC);
    @(posedge clk); #1; m_ready = 1'b1;
    wait_done();
    chk("hold_cs_accepted", {16'b0, last_cs}, 32'h22CC);

    // verify, 32-bit
    sel = 1; mode = 1'b1; clr_pk();
    pk_d[0] = 128'h4500002E; pk_d[1] = 128'h00000000; pk_d[2] = 128'h800022CC;
    pk_d[3] = 128'h01010B02; pk_d[4] = 128'h01010B01;
    send_pkt(5, 0); wait_done();
    chk("v32_cs", {16'b0, last_cs}, 32'hFFFF);
    chk("v32_ok", {31'b0, last_ok}, 32'd1);
    pk_d[0] = 128'h4501002E;
    send_pkt(5, 0); wait_done();
    chk("v32_bad_ok", {31'b0, last_ok}, 32'd0);
    chk("v32_bad_cs", {16'b0, last_cs}, 32'h0001);

    // generate, 64-bit, negative zero with partial lanes; then with input gaps
    sel = 2; mode = 1'b0; clr_pk();
    pk_le[1] = 8'h0C;
    send_pkt(2, 0); wait_done();
    chk("g64_zero_cs", {16'b0, last_cs}, 32'hFFFF);
    pk_d[0] = 128'h1234_0000_ABCD_0001; pk_d[1] = 128'hFFFF_FFFF_FFFF_FFFF; pk_d[2] = 128'h0F0F_F0F0_0000_8000;
    pk_le[1] = 8'h05;
    send_pkt(3, 0); wait_done();
    rc0 = 32'(last_cs);
    send_pkt(3, 1); wait_done();
    chk("g64_gaps_same", {16'b0, last_cs}, rc0);

    // overflow with MAX_BEATS = 4, then a clean packet
    sel = 3; clr_pk();
    for (int i = 0; i < 5; i++) pk_d[i] = 'hFFFF;
    send_pkt(5, 0); wait_done();
    chk("ovf_err", {31'b0, last_err}, 32'd1);
    chk("ovf_ok", {31'b0, last_ok}, 32'd0);
    pk_d[0] = 'h0001;
    send_pkt(1, 0); wait_done();
    chk("post_ovf_err", {31'b0, last_err}, 32'd0);
    chk("post_ovf_cs", {16'b0, last_cs}, 32'hFFFE);

    // reset during the third beat discards the packet
    sel = 0; rc0 = results;
    beat('h1111, 8'hFF, 1'b0);
    beat('h2222, 8'hFF, 1'b0);
    d = 'h3333; valid = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    valid = 1'b0; m_sum = 0; m_beats = 0; expq.delete();
    #2;
    chk_reset_all();
    sel = 0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    clr_pk(); pk_d[0] = 'h0001;
    send_pkt(1, 0); wait_done();
    chk("rst_one_result", 32'(results - rc0), 32'd1);
    chk("rst_result_cs", {16'b0, last_cs}, 32'hFFFE);

    // back-to-back packets with m_ready high
    sel = 1; clr_pk();
    pk_d[0] = 128'h00010002; pk_d[1] = 128'h00030004;
    send_pkt(2, 0);
    send_pkt(2, 0);
    wait_done();
    chk("b2b_gap", 32'(last_gap), 32'd3);
    chk("b2b_cs", {16'b0, last_cs}, 32'hFFF5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ip_checksum_stream.md
Name: ip_checksum_stream

Overview:
- Streaming, parametrised successor to the combinational IPv4 header checksum calculator.
- Accepts a header (or any 16-bit-word buffer) as a valid/ready stream of DATA_WIDTH-bit beats and accumulates the ones-complement sum.
- Folds the end-around carries and returns one result per packet through a held output handshake.
- Two modes: generate (returns the checksum to insert) and verify (checks a received header that includes its checksum field). Sits between the packet builder/parser and the TX/RX framing logic.

Parameters:
- DATA_WIDTH, 32, beat width in bits; multiple of 16, range 16..128; LANES = DATA_WIDTH/16.
- MAX_BEATS, 64, maximum beats per packet; LANES*MAX_BEATS must be <= 65535.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- MODE  in  1  0 = generate, 1 = verify; sampled on the first accepted beat of a packet.
- S_DATA  in  DATA_WIDTH  packet words, network order; lane 0 = S_DATA[DATA_WIDTH-1 -: 16].
- S_LANE_EN  in  LANES  per-lane enable; a disabled lane contributes 0; bit LANES-1 maps to lane 0.
- S_LAST  in  1  final beat of packet.
- S_VALID  in  1  input beat valid.
- S_READY  out  1  input ready.
- M_CHECKSUM  out  16  generate: ~folded_sum; verify: folded_sum.
- M_OK  out  1  verify: folded_sum == 16'hFFFF; generate: always 1.
- M_ERR  out  1  beat count exceeded MAX_BEATS.
- M_VALID  out  1  result valid.
- M_READY  in  1  result accepted.

Behaviour:
- Reset (async assert, sync release) values:
  - state = ACCUM; accumulator = 0; beat count = 0.
  - S_READY = 1; M_VALID = 0; M_CHECKSUM = 16'h0000; M_OK = 0; M_ERR = 0.
- Accumulator width: ACC_W = 16 + clog2(LANES*MAX_BEATS) + 1, at most 33. Per-beat lane sums are added unsigned with no truncation.
- States:
  - ACCUM:
    - S_READY = 1.
    - On each S_VALID & S_READY: acc += sum of enabled lanes; beat count increments, saturating at MAX_BEATS+1.
    - MODE is latched on the first beat.
    - When the handshaken beat has S_LAST = 1, go to FOLD1.
  - FOLD1: S_READY = 0; acc = acc[15:0] + acc[ACC_W-1:16]. Always go to FOLD2.
  - FOLD2: S_READY = 0; acc = acc[15:0] + acc[ACC_W-1:16], which leaves a 16-bit result. Register M_CHECKSUM, M_OK and M_ERR, set M_VALID = 1, go to DONE.
  - DONE:
    - S_READY = 0; outputs held stable while M_VALID & !M_READY.
    - On M_READY: M_VALID = 0 next cycle; acc, beat count and the error flag clear; return to ACCUM.
- Latency: LAST accepted at edge n -> M_VALID = 1 after edge n+2, i.e. 3 cycles from LAST handshake to result. Fixed and independent of data.
- Throughput:
  - One beat per cycle inside a packet.
  - 3 dead cycles minimum between packets (FOLD1, FOLD2, DONE with M_READY tied high).
  - S_READY re-asserts the cycle after the DONE handshake. It is never combinationally dependent on M_READY.
- Negative zero:
  - All-zero input gives folded_sum = 16'h0000, so generate returns 16'hFFFF.
  - A folded_sum of 16'hFFFF is never replaced with 0.
- Single-beat packet (S_LAST on the first beat) is legal and follows the same path.
- All lanes disabled on a beat: the beat counts, contributes 0, and is legal.
- Overflow:
  - A beat accepted when count == MAX_BEATS sets a sticky error flag.
  - Accumulation continues, with wrap allowed in the top bits; the result is not trusted.
  - M_ERR = 1 and M_OK = 0 on that result.
- S_VALID low mid-packet: the accumulator holds and no timeout applies.
- RST_N asserted mid-packet or mid-result: the packet is discarded immediately, all outputs go to reset values, and no partial result is emitted.
- S_DATA, S_LANE_EN and S_LAST are ignored when S_VALID = 0 or S_READY = 0.

Test Plan:
- Generate, DATA_WIDTH=32; beats 45000030, 44224000, 80060000, 8C7C19AC, AE241E2B (LAST), all lanes on -> M_CHECKSUM = 16'h442E, M_OK = 1, M_ERR = 0, M_VALID rising 3 cycles after the LAST handshake.
- Generate, DATA_WIDTH=16; words 4500, 002E, 0000, 0000, 8000, 0000, 0101, 0B02, 0101, 0B01 -> M_CHECKSUM = 16'h22CC. Repeat with M_READY held low 5 cycles -> outputs stable and S_READY = 0 throughout.
- Verify, DATA_WIDTH=32: previous vector with 0000 replaced by 22CC -> M_CHECKSUM = 16'hFFFF, M_OK = 1. Flip bit 0 of the first word -> M_OK = 0.
- Generate, DATA_WIDTH=64; 2 beats of all zeros, second beat with S_LANE_EN = 4'b1100 -> M_CHECKSUM = 16'hFFFF. Random S_VALID gaps give an identical result.
- MAX_BEATS=4, DATA_WIDTH=16; 5 beats of FFFF -> M_ERR = 1, M_OK = 0. A following legal packet 0001, LAST -> M_ERR = 0, M_CHECKSUM = 16'hFFFE.
- Assert RST_N low during the third beat, then send a 1-beat packet 0001 -> only one result seen, M_CHECKSUM = 16'hFFFE. Back-to-back packets with M_READY = 1 -> exactly 3 cycles with S_READY = 0 between them.
